// File: rtl/r4_operand_loader.sv
// r4_operand_loader: debounces the getA/getX/start buttons, assembles two
// 16-bit operands from byte-serial switch reads, and offers them to the
// radix-4 multiplier under a valid/ack handshake.
module r4_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in,
  input  logic        getA,
  input  logic        getX,
  input  logic        start,
  input  logic        op_ack,
  output logic [15:0] a_out,
  output logic [15:0] x_out,
  output logic        op_valid,
  output logic [2:0]  stage
);

  localparam int unsigned NBTN  = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_X = 1;
  localparam int unsigned BTN_S = 2;
  // The counter saturates one short of the threshold; the next differing
  // sample is the one that reaches DEBOUNCE_CYCLES and flips the level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    A_LSB = 3'd0,
    A_MSB = 3'd1,
    X_LSB = 3'd2,
    X_MSB = 3'd3,
    ARMED = 3'd4,
    VALID = 3'd5
  } state_e;

  logic [NBTN-1:0]            btn_raw;
  logic [NBTN-1:0]            sync1_q, sync1_d;
  logic [NBTN-1:0]            sync2_q, sync2_d;
  logic [NBTN-1:0]            db_q, db_d;
  logic [NBTN-1:0]            press_q, press_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] x_q, x_d;
  logic        valid_q, valid_d;

  // Synchronize, debounce and edge-detect each button independently.
  always_comb begin
    btn_raw = {start, getX, getA};
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    press_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]    = sync2_q[i];
          // A change away from released (1) is a press.
          press_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state, operand capture and valid generation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    case (state_q)
      A_LSB: if (press_q[BTN_A]) begin
        a_d[7:0] = in;
        state_d  = A_MSB;
      end
      A_MSB: if (press_q[BTN_A]) begin
        a_d[15:8] = in;
        state_d   = X_LSB;
      end
      X_LSB: if (press_q[BTN_X]) begin
        x_d[7:0] = in;
        state_d  = X_MSB;
      end
      X_MSB: if (press_q[BTN_X]) begin
        x_d[15:8] = in;
        state_d   = ARMED;
      end
      ARMED: if (press_q[BTN_S]) state_d = VALID;
      VALID: if (op_ack) state_d = A_LSB;
      default: state_d = A_LSB;
    endcase
    valid_d = (state_d == VALID);
  end

  // State and datapath registers; reset leaves all buttons released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      press_q <= '0;
      cnt_q   <= '0;
      state_q <= A_LSB;
      a_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      valid_q <= valid_d;
    end
  end

  assign a_out    = a_q;
  assign x_out    = x_q;
  assign op_valid = valid_q;
  assign stage    = state_q;

endmodule
